// File: rtl/wb_req_arbiter.sv
// Writeback request arbiter: three per-source in-order FIFOs (ALU, MUL, dcache)
// feeding one registered output slot toward the reorder-buffer write port.
// Heads are granted round-robin, and per-thread flush kills buffered and
// in-slot requests so that squashed results never reach the ROB.
module wb_req_arbiter #(
   parameter int DATA_W  = 96,
   parameter int THR_W   = 2,
   parameter int NUM_THR = 4,
   parameter int DEPTH   = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               alu_req_valid,
   input  logic [DATA_W-1:0]  alu_req_info,
   input  logic [THR_W-1:0]   alu_thread_id,
   output logic               alu_req_ready,
   input  logic               mul_req_valid,
   input  logic [DATA_W-1:0]  mul_req_info,
   input  logic [THR_W-1:0]   mul_thread_id,
   output logic               mul_req_ready,
   input  logic               cache_req_valid,
   input  logic [DATA_W-1:0]  cache_req_info,
   input  logic [THR_W-1:0]   cache_thread_id,
   output logic               cache_req_ready,
   input  logic [NUM_THR-1:0] flush,
   input  logic               rob_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_info,
   output logic [THR_W-1:0]   out_thread_id,
   output logic [1:0]         out_source
);

   localparam int         NS      = 3;
   localparam logic [2:0] DEPTH_C = 3'(DEPTH);
   localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

   // Storage is sized for the largest supported depth; pointers wrap at DEPTH.
   logic [DATA_W-1:0] info_q [NS][4];
   logic [DATA_W-1:0] info_d [NS][4];
   logic [THR_W-1:0]  thr_q  [NS][4];
   logic [THR_W-1:0]  thr_d  [NS][4];
   logic [3:0]        live_q [NS];
   logic [3:0]        live_d [NS];
   logic [1:0]        rd_q   [NS];
   logic [1:0]        rd_d   [NS];
   logic [1:0]        wr_q   [NS];
   logic [1:0]        wr_d   [NS];
   logic [2:0]        cnt_q  [NS];
   logic [2:0]        cnt_d  [NS];
   logic [1:0]        rr_q, rr_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_info_q, out_info_d;
   logic [THR_W-1:0]  out_thr_q, out_thr_d;
   logic [1:0]        out_src_q, out_src_d;

   logic [NS-1:0]     in_valid;
   logic [DATA_W-1:0] in_info [NS];
   logic [THR_W-1:0]  in_thr  [NS];
   logic [NS-1:0]     ready, push, eligible, discard, take, pop;
   logic [DATA_W-1:0] head_info [NS];
   logic [THR_W-1:0]  head_thr  [NS];
   logic              load, found;
   logic [1:0]        rr_eff, gnt_idx, idx_c;
   logic [2:0]        sum_c;

   assign in_valid   = {cache_req_valid, mul_req_valid, alu_req_valid};
   assign in_info[0] = alu_req_info;
   assign in_info[1] = mul_req_info;
   assign in_info[2] = cache_req_info;
   assign in_thr[0]  = alu_thread_id;
   assign in_thr[1]  = mul_thread_id;
   assign in_thr[2]  = cache_thread_id;

   assign alu_req_ready   = ready[0];
   assign mul_req_ready   = ready[1];
   assign cache_req_ready = ready[2];
   assign out_valid       = out_valid_q;
   assign out_info        = out_info_q;
   assign out_thread_id   = out_thr_q;
   assign out_source      = out_src_q;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == LAST_C) ? 2'd0 : p + 2'd1;
   endfunction

   // Per-source status: ready from registered count, head eligibility and dead-head discard.
   always_comb begin
      for (int s = 0; s < NS; s++) begin
         ready[s]     = (cnt_q[s] < DEPTH_C);
         push[s]      = in_valid[s] && ready[s];
         head_info[s] = info_q[s][rd_q[s]];
         head_thr[s]  = thr_q[s][rd_q[s]];
         eligible[s]  = (cnt_q[s] != 3'd0) && live_q[s][rd_q[s]] && !flush[head_thr[s]];
         discard[s]   = (cnt_q[s] != 3'd0) && !live_q[s][rd_q[s]];
      end
   end

   // Round-robin grant from rr_ptr and next value of the output slot.
   always_comb begin
      load        = !out_valid_q || rob_ready;
      rr_eff      = (rr_q == 2'd3) ? 2'd0 : rr_q;
      found       = 1'b0;
      gnt_idx     = 2'd0;
      sum_c       = 3'd0;
      idx_c       = 2'd0;
      for (int i = 0; i < NS; i++) begin
         sum_c = {1'b0, rr_eff} + 3'(i);
         idx_c = (sum_c >= 3'd3) ? 2'(sum_c - 3'd3) : 2'(sum_c);
         if (!found && eligible[idx_c]) begin
            found   = 1'b1;
            gnt_idx = idx_c;
         end
      end
      for (int s = 0; s < NS; s++) begin
         take[s] = load && found && (gnt_idx == 2'(s));
         pop[s]  = take[s] || discard[s];
      end
      rr_d        = rr_eff;
      out_valid_d = out_valid_q;
      out_info_d  = out_info_q;
      out_thr_d   = out_thr_q;
      out_src_d   = out_src_q;
      if (load) begin
         if (found) begin
            out_valid_d = 1'b1;
            out_info_d  = head_info[gnt_idx];
            out_thr_d   = head_thr[gnt_idx];
            out_src_d   = gnt_idx;
            rr_d        = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (flush[out_thr_q]) begin
         out_valid_d = 1'b0;
      end
   end

   // FIFO next state: flush kills entries, push writes tail (killed if its thread flushes), pop advances head.
   always_comb begin
      for (int s = 0; s < NS; s++) begin
         info_d[s] = info_q[s];
         thr_d[s]  = thr_q[s];
         rd_d[s]   = rd_q[s];
         wr_d[s]   = wr_q[s];
         for (int e = 0; e < 4; e++) begin
            live_d[s][e] = live_q[s][e] && !flush[thr_q[s][e]];
         end
         if (push[s]) begin
            info_d[s][wr_q[s]] = in_info[s];
            thr_d[s][wr_q[s]]  = in_thr[s];
            live_d[s][wr_q[s]] = !flush[in_thr[s]];
            wr_d[s]            = next_ptr(wr_q[s]);
         end
         if (pop[s]) begin
            rd_d[s] = next_ptr(rd_q[s]);
         end
         cnt_d[s] = cnt_q[s] + 3'(push[s]) - 3'(pop[s]);
      end
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NS; s++) begin
            for (int e = 0; e < 4; e++) begin
               info_q[s][e] <= '0;
               thr_q[s][e]  <= '0;
            end
            live_q[s] <= '0;
            rd_q[s]   <= '0;
            wr_q[s]   <= '0;
            cnt_q[s]  <= '0;
         end
         rr_q        <= 2'd0;
         out_valid_q <= 1'b0;
         out_info_q  <= '0;
         out_thr_q   <= '0;
         out_src_q   <= 2'd0;
      end else begin
         info_q      <= info_d;
         thr_q       <= thr_d;
         live_q      <= live_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_info_q  <= out_info_d;
         out_thr_q   <= out_thr_d;
         out_src_q   <= out_src_d;
      end
   end

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Bench for wb_req_arbiter: vector table for latency and killed-push
// behaviour, plus sequences for round-robin streaming, full FIFO backpressure,
// flush of the slot and queue, and asynchronous reset.
module tb_wb_req_arbiter;
   localparam int DATA_W = 96, THR_W = 2, NUM_THR = 4, DEPTH = 2;

   logic               clock = 1'b0;
   logic               reset;
   logic               alu_req_valid, mul_req_valid, cache_req_valid;
   logic [DATA_W-1:0]  alu_req_info, mul_req_info, cache_req_info;
   logic [THR_W-1:0]   alu_thread_id, mul_thread_id, cache_thread_id;
   logic               alu_req_ready, mul_req_ready, cache_req_ready;
   logic [NUM_THR-1:0] flush;
   logic               rob_ready;
   logic               out_valid;
   logic [DATA_W-1:0]  out_info;
   logic [THR_W-1:0]   out_thread_id;
   logic [1:0]         out_source;

   wb_req_arbiter #(.DATA_W(DATA_W), .THR_W(THR_W), .NUM_THR(NUM_THR), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .alu_req_valid(alu_req_valid), .alu_req_info(alu_req_info),
      .alu_thread_id(alu_thread_id), .alu_req_ready(alu_req_ready),
      .mul_req_valid(mul_req_valid), .mul_req_info(mul_req_info),
      .mul_thread_id(mul_thread_id), .mul_req_ready(mul_req_ready),
      .cache_req_valid(cache_req_valid), .cache_req_info(cache_req_info),
      .cache_thread_id(cache_thread_id), .cache_req_ready(cache_req_ready),
      .flush(flush), .rob_ready(rob_ready),
      .out_valid(out_valid), .out_info(out_info),
      .out_thread_id(out_thread_id), .out_source(out_source)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic               a_v;
      logic [DATA_W-1:0]  a_info;
      logic [THR_W-1:0]   a_tid;
      logic [NUM_THR-1:0] fl;
      logic               rr;
      logic               e_v;
      logic [DATA_W-1:0]  e_info;
      logic [THR_W-1:0]   e_thr;
      logic [1:0]         e_src;
      logic               e_ardy;
   } vec_t;

   vec_t vt [9];
   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] sbq0 [$];
   logic [DATA_W-1:0] sbq1 [$];
   logic [DATA_W-1:0] sbq2 [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      alu_req_valid = 0; mul_req_valid = 0; cache_req_valid = 0;
      alu_req_info = '0; mul_req_info = '0; cache_req_info = '0;
      alu_thread_id = '0; mul_thread_id = '0; cache_thread_id = '0;
      flush = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Pops the expected payload for the source shown on the output and compares.
   task automatic sb_check(input logic [1:0] src, input logic [DATA_W-1:0] info);
      logic [DATA_W-1:0] exp;
      int sz;
      sz = (src == 2'd0) ? sbq0.size() : (src == 2'd1) ? sbq1.size() : (src == 2'd2) ? sbq2.size() : 0;
      if (sz == 0) begin
         check("rr_unexpected_output", 128'(src), 128'(3));
      end else begin
         if (src == 2'd0) exp = sbq0.pop_front();
         else if (src == 2'd1) exp = sbq1.pop_front();
         else exp = sbq2.pop_front();
         check("rr_payload_order", 128'(info), 128'(exp));
      end
   endtask

   initial begin
      logic [87:0] cnt [3];
      logic [1:0]  exp_src;
      int          acc;

      rob_ready = 1'b0;
      do_reset();

      // Reset state
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_info", 128'(out_info), 128'(0));
      check("rst_out_thr", 128'(out_thread_id), 128'(0));
      check("rst_out_src", 128'(out_source), 128'(0));
      check("rst_alu_ready", 128'(alu_req_ready), 128'(1));
      check("rst_mul_ready", 128'(mul_req_ready), 128'(1));
      check("rst_cache_ready", 128'(cache_req_ready), 128'(1));

      // Vector table: each row's inputs drive one cycle; expectations are the outputs after that edge.
      vt[0] = '{1'b1, 96'h11, 2'd1, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[1] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b1, 96'h11, 2'd1, 2'd0, 1'b1};
      vt[2] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[3] = '{1'b1, 96'h22, 2'd0, 4'b0001, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[4] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[5] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[6] = '{1'b1, 96'h33, 2'd0, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      vt[7] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b1, 96'h33, 2'd0, 2'd0, 1'b1};
      vt[8] = '{1'b0, 96'h0,  2'd0, 4'b0000, 1'b1, 1'b0, 96'h0,  2'd0, 2'd0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         alu_req_valid = vt[i].a_v;
         alu_req_info  = vt[i].a_info;
         alu_thread_id = vt[i].a_tid;
         flush         = vt[i].fl;
         rob_ready     = vt[i].rr;
         tick();
         check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vt[i].e_v));
         if (vt[i].e_v) begin
            check($sformatf("vec%0d_out_info", i), 128'(out_info), 128'(vt[i].e_info));
            check($sformatf("vec%0d_out_thr", i), 128'(out_thread_id), 128'(vt[i].e_thr));
            check($sformatf("vec%0d_out_src", i), 128'(out_source), 128'(vt[i].e_src));
         end
         check($sformatf("vec%0d_alu_ready", i), 128'(alu_req_ready), 128'(vt[i].e_ardy));
      end

      // Round-robin streaming from all three sources with rob_ready held high.
      do_reset();
      rob_ready = 1'b1;
      for (int s = 0; s < 3; s++) cnt[s] = '0;
      exp_src = 2'd0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         alu_req_valid = 1'b1;   alu_req_info   = {8'd1, cnt[0]}; alu_thread_id   = cnt[0][1:0];
         mul_req_valid = 1'b1;   mul_req_info   = {8'd2, cnt[1]}; mul_thread_id   = cnt[1][1:0];
         cache_req_valid = 1'b1; cache_req_info = {8'd3, cnt[2]}; cache_thread_id = cnt[2][1:0];
         if (out_valid) begin
            check("rr_source_rotation", 128'(out_source), 128'(exp_src));
            sb_check(out_source, out_info);
            exp_src = (exp_src == 2'd2) ? 2'd0 : exp_src + 2'd1;
         end
         if (alu_req_ready)   begin sbq0.push_back(alu_req_info);   cnt[0] = cnt[0] + 88'd1; end
         if (mul_req_ready)   begin sbq1.push_back(mul_req_info);   cnt[1] = cnt[1] + 88'd1; end
         if (cache_req_ready) begin sbq2.push_back(cache_req_info); cnt[2] = cnt[2] + 88'd1; end
         tick();
      end
      idle_inputs();
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_valid) sb_check(out_source, out_info);
         tick();
      end
      check("rr_no_loss", 128'(sbq0.size() + sbq1.size() + sbq2.size()), 128'(0));
      check("rr_all_accepted", 128'(cnt[0] > 88'd8), 128'(1));

      // Full FIFO: ALU streams into a stalled ROB.
      do_reset();
      rob_ready = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         alu_req_valid = 1'b1;
         alu_req_info  = 96'h100 + 96'(acc);
         alu_thread_id = 2'd1;
         if (alu_req_ready) acc++;
         tick();
      end
      check("full_accepts", 128'(acc), 128'(3));
      check("full_ready_low", 128'(alu_req_ready), 128'(0));
      check("full_held_valid", 128'(out_valid), 128'(1));
      check("full_held_info", 128'(out_info), 128'(96'h100));
      alu_req_valid = 1'b0;
      rob_ready = 1'b1;
      tick();
      check("full_ready_back", 128'(alu_req_ready), 128'(1));
      check("full_drain1", 128'(out_info), 128'(96'h101));
      tick();
      check("full_drain2", 128'(out_info), 128'(96'h102));
      check("full_drain2_valid", 128'(out_valid), 128'(1));
      tick();
      check("full_drained", 128'(out_valid), 128'(0));

      // Flush of thread 2 with its request in the slot and another at the MUL head.
      do_reset();
      rob_ready = 1'b0;
      mul_req_valid = 1'b1; mul_req_info = 96'hA0; mul_thread_id = 2'd2; tick();
      mul_req_info = 96'hB0; mul_thread_id = 2'd2; tick();
      mul_req_info = 96'hC0; mul_thread_id = 2'd3; tick();
      mul_req_valid = 1'b0;
      check("fl_slot_info", 128'(out_info), 128'(96'hA0));
      check("fl_slot_thr", 128'(out_thread_id), 128'(2));
      check("fl_slot_src", 128'(out_source), 128'(1));
      check("fl_mul_full", 128'(mul_req_ready), 128'(0));
      flush = 4'b0100;
      rob_ready = 1'b1;
      tick();
      flush = 4'b0000;
      check("fl_slot_cleared", 128'(out_valid), 128'(0));
      tick();
      check("fl_discard_no_out", 128'(out_valid), 128'(0));
      check("fl_discard_ready", 128'(mul_req_ready), 128'(1));
      tick();
      check("fl_t3_valid", 128'(out_valid), 128'(1));
      check("fl_t3_info", 128'(out_info), 128'(96'hC0));
      check("fl_t3_thr", 128'(out_thread_id), 128'(3));
      check("fl_t3_src", 128'(out_source), 128'(1));
      tick();
      check("fl_end_empty", 128'(out_valid), 128'(0));

      // Asynchronous reset mid-stream.
      do_reset();
      rob_ready = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         alu_req_valid = 1'b1; alu_req_info = 96'h200 + 96'(cyc); alu_thread_id = 2'd0;
         tick();
      end
      alu_req_valid = 1'b0;
      check("ar_pre_valid", 128'(out_valid), 128'(1));
      #2 reset = 1'b1;
      #1;
      check("ar_valid_now", 128'(out_valid), 128'(0));
      check("ar_alu_ready_now", 128'(alu_req_ready), 128'(1));
      check("ar_mul_ready_now", 128'(mul_req_ready), 128'(1));
      check("ar_cache_ready_now", 128'(cache_req_ready), 128'(1));
      tick();
      reset = 1'b0;
      rob_ready = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         tick();
         check("ar_no_stale", 128'(out_valid), 128'(0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
